// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM state encoding,
// byte-lane mask constants and a lane-mask expansion helper.
package dmem_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  // Expands a 4-bit byte-lane mask to a 32-bit bit mask.
  function automatic word_t lane_bits(input logic [3:0] mask);
    word_t bits;
    bits = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        bits[8*i +: 8] = 8'hFF;
      end else begin
        bits[8*i +: 8] = 8'h00;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 byte-enabled storage with a registered, lane-gated read port.
// Lanes not enabled on the read port return zero, so the read register is the output data.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_raddr,
  input  logic [3:0]    i_rlanes,
  input  logic [AW-1:0] i_waddr,
  input  logic [3:0]    i_wlanes,
  input  word_t         i_wdata,
  output word_t         o_rdata
);

  word_t r_mem [DEPTH_WORDS];
  word_t r_rdata;

  // Per-byte write; storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_wlanes[i]) begin
        r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Registered read; disabled lanes and reset both force zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_rdata[8*i +: 8] <= i_rlanes[i] ? r_mem[i_raddr][8*i +: 8] : 8'h00;
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency, byte-enabled data-memory responder (IDLE -> WAIT -> RESP).
// Optional counters of reads/writes/errors are enabled by defining DMEM_RESPONDER_STATS_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_err
`ifdef DMEM_RESPONDER_STATS_EN
  ,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_errs
`endif
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);

  state_e        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_rmask;
  logic [3:0]    r_wmask;
  word_t         r_wdata;
  logic          r_err;
  logic          r_resp;
  logic          r_err_out;

  logic          w_req;
  logic          w_in_err;
  logic [AW-1:0] w_raddr;
  logic [3:0]    w_rlanes;
  logic [3:0]    w_wlanes;

  assign w_req    = (dmem_rmask != MASK_NONE) || (dmem_wmask != MASK_NONE);
  // Comparing the byte address covers the word-index bound without dropping bits.
  assign w_in_err = ((dmem_rmask != MASK_NONE) && (dmem_wmask != MASK_NONE)) ||
                    (dmem_addr >= BYTE_LIMIT);

  // Read lanes are enabled only on the edge that enters RESP, so rdata is zero otherwise.
  always_comb begin
    w_raddr  = r_addr;
    w_rlanes = MASK_NONE;
    if ((r_state == IDLE) && w_req && (LATENCY == 1)) begin
      w_raddr  = dmem_addr[AW+1:2];
      w_rlanes = w_in_err ? MASK_NONE : dmem_rmask;
    end else if ((r_state == WAIT) && (r_cnt == 4'd1)) begin
      w_raddr  = r_addr;
      w_rlanes = r_err ? MASK_NONE : r_rmask;
    end else begin
      w_raddr  = r_addr;
      w_rlanes = MASK_NONE;
    end
  end

  // The write lands on the edge that ends RESP; a reset on that edge drops it.
  assign w_wlanes = ((r_state == RESP) && !r_err && rst) ? r_wmask : MASK_NONE;

  // Transaction FSM, latency counter and holding registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_rmask   <= MASK_NONE;
      r_wmask   <= MASK_NONE;
      r_wdata   <= 32'h0000_0000;
      r_err     <= 1'b0;
      r_resp    <= 1'b0;
      r_err_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp    <= 1'b0;
          r_err_out <= 1'b0;
          if (w_req) begin
            r_addr  <= dmem_addr[AW+1:2];
            r_rmask <= dmem_rmask;
            r_wmask <= dmem_wmask;
            r_wdata <= dmem_wdata;
            r_err   <= w_in_err;
            r_cnt   <= LAT_M1;
            if (LATENCY > 1) begin
              r_state <= WAIT;
            end else begin
              r_state   <= RESP;
              r_resp    <= 1'b1;
              r_err_out <= w_in_err;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state   <= RESP;
            r_resp    <= 1'b1;
            r_err_out <= r_err;
          end else begin
            r_state <= WAIT;
          end
        end
        RESP: begin
          r_state   <= IDLE;
          r_resp    <= 1'b0;
          r_err_out <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_resp    <= 1'b0;
          r_err_out <= 1'b0;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_raddr (w_raddr),
    .i_rlanes(w_rlanes),
    .i_waddr (r_addr),
    .i_wlanes(w_wlanes),
    .i_wdata (r_wdata),
    .o_rdata (dmem_rdata)
  );

  assign dmem_resp = r_resp;
  assign dmem_err  = r_err_out;

`ifdef DMEM_RESPONDER_STATS_EN
  logic [31:0] r_stat_reads;
  logic [31:0] r_stat_writes;
  logic [31:0] r_stat_errs;

  // Saturating completion counters, classified while the response pulse is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_reads  <= 32'd0;
      r_stat_writes <= 32'd0;
      r_stat_errs   <= 32'd0;
    end else if (r_resp) begin
      if (r_err_out) begin
        if (r_stat_errs != 32'hFFFF_FFFF) r_stat_errs <= r_stat_errs + 32'd1;
        else r_stat_errs <= r_stat_errs;
      end else if (r_rmask != MASK_NONE) begin
        if (r_stat_reads != 32'hFFFF_FFFF) r_stat_reads <= r_stat_reads + 32'd1;
        else r_stat_reads <= r_stat_reads;
      end else begin
        if (r_stat_writes != 32'hFFFF_FFFF) r_stat_writes <= r_stat_writes + 32'd1;
        else r_stat_writes <= r_stat_writes;
      end
    end else begin
      r_stat_reads <= r_stat_reads;
    end
  end

  assign stat_reads  = r_stat_reads;
  assign stat_writes = r_stat_writes;
  assign stat_errs   = r_stat_errs;
`endif

endmodule
